booth_r4_mult_seq: RTL

- Parametrised sequential radix-4 Booth multiplier for the FPU multiply path. It takes two W-bit operands, signed or unsigned per transaction, and returns the exact 2W-bit product.
- Input and output use valid/ready handshakes, so it sits between the exponent/unpack stage and the normaliser/rounder.
- Generalises the fixed-width free-running mantissa multiplier: configurable width, per-transaction signed/unsigned mode, start/finish handshakes, and backpressure.

---
 rtl/booth_r4_mult_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/booth_r4_mult_seq.sv
// Sequential radix-4 Booth multiplier: W-bit signed/unsigned operands, exact 2W-bit product,
// valid/ready on both sides. Optional macro BOOTH_ZERO_SKIP_EN lets zero operands bypass the loop.
module booth_r4_mult_seq #(
    parameter int W = 24
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           signed_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product
);

    // EW is even and at least W+1, so both extended operands are valid signed EW-bit values.
    localparam int EW   = 2 * ((W + 2) / 2);
    localparam int N_IT = EW / 2;
    localparam int AW   = 2 * EW + 1;
    localparam int CW   = $clog2(N_IT + 1);

    if (W < 4 || W > 64) begin : g_bad_width
        $error("booth_r4_mult_seq: W must lie in 4..64");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [AW-1:0]   acc;
    logic                   guard;
    logic signed [EW-1:0]   m;
    logic [CW-1:0]          cnt;

    logic [EW-1:0]          a_ext;
    logic [EW-1:0]          b_ext;
    logic                   last_iter;
    logic                   skip;
    logic signed [EW+1:0]   m_wide;
    logic signed [EW+1:0]   hi_wide;
    logic signed [EW+1:0]   addend;
    logic signed [EW+1:0]   hi_sum;
    logic signed [AW:0]     shift_src;
    logic signed [AW-1:0]   acc_nxt;

    assign a_ext = signed_mode ? {{(EW-W){a[W-1]}}, a} : {{(EW-W){1'b0}}, a};
    assign b_ext = signed_mode ? {{(EW-W){b[W-1]}}, b} : {{(EW-W){1'b0}}, b};

`ifdef BOOTH_ZERO_SKIP_EN
    assign skip = (a == '0) || (b == '0);
`else
    assign skip = 1'b0;
`endif

    assign last_iter = (cnt == CW'(N_IT - 1));

    // Upper half carries two spare bits so that +/-2M never overflows before the shift.
    assign m_wide  = {{2{m[EW-1]}}, m};
    assign hi_wide = {acc[AW-1], acc[AW-1:EW]};

    always_comb begin
        addend = '0;
        case ({acc[1], acc[0], guard})
            3'b001, 3'b010: addend = m_wide;
            3'b011:         addend = m_wide <<< 1;
            3'b100:         addend = -(m_wide <<< 1);
            3'b101, 3'b110: addend = -m_wide;
            default:        addend = '0;
        endcase
    end

    assign hi_sum    = hi_wide + addend;
    assign shift_src = {hi_sum, acc[EW-1:0]};
    assign acc_nxt   = AW'(shift_src >>> 2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = skip ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are only captured in IDLE; product only changes on the way into DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc     <= '0;
            guard   <= 1'b0;
            m       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m     <= a_ext;
                        acc   <= {{(EW+1){1'b0}}, b_ext};
                        guard <= 1'b0;
                        cnt   <= '0;
                        if (skip) begin
                            product <= '0;
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_nxt;
                    guard <= acc[1];
                    cnt   <= cnt + CW'(1);
                    if (last_iter) begin
                        product <= acc_nxt[2*W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
